// File: rtl/downsample_pkg.sv
// Shared definitions for the 2-D downsampler: stride clamping and output-buffer sizing.
package downsample_pkg;

  // Output buffer holds two beats so a kept pixel can be accepted every cycle.
  localparam int unsigned SkidDepth = 2;

  // Occupancy count of the output buffer (0..SkidDepth).
  typedef logic [1:0] skid_cnt_t;

  // Map a configured stride onto the supported range: 0 behaves as 1, large values saturate.
  function automatic int unsigned clamp_stride(input int unsigned cfg,
                                               input int unsigned max_stride);
    if (cfg == 0) begin
      return 1;
    end
    if (cfg > max_stride) begin
      return max_stride;
    end
    return cfg;
  endfunction

endpackage

// File: rtl/downsample_skid.sv
// Two-entry output buffer. in_ready is a registered "not full" flag, so the upstream
// accept decision never depends combinationally on out_ready.
module downsample_skid
  import downsample_pkg::*;
#(
  parameter int unsigned WIDTH = 17
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  skid_cnt_t        cnt_q;
  skid_cnt_t        cnt_d;
  logic             full_q;
  logic             push;
  logic             pop;

  assign push      = in_valid & ~full_q;
  assign pop       = (cnt_q != '0) & out_ready;
  assign in_ready  = ~full_q;
  assign out_valid = (cnt_q != '0);
  assign out_data  = head_q;

  // Next occupancy from the push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + skid_cnt_t'(1);
      2'b01:   cnt_d = cnt_q - skid_cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Entry storage and the registered full flag; head only moves on a pop, keeping it stable.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == skid_cnt_t'(SkidDepth));
      case (cnt_q)
        skid_cnt_t'(0): begin
          if (push) head_q <= in_data;
        end
        skid_cnt_t'(1): begin
          if (push && pop) begin
            head_q <= in_data;
          end else if (push) begin
            tail_q <= in_data;
          end
        end
        default: begin
          // Full: no push possible, a pop promotes the tail.
          if (pop) head_q <= tail_q;
        end
      endcase
    end
  end

endmodule

// File: rtl/downsample_2d.sv
// Raster-order 2-D downsampler: keeps pixels whose column and row are multiples of the
// active strides, tags the final kept pixel of each frame and pulses frame_done.
module downsample_2d
  import downsample_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IMG_WIDTH  = 32,
  parameter int unsigned IMG_HEIGHT = 32,
  parameter int unsigned MAX_STRIDE = 4,
  localparam int unsigned XW = $clog2(IMG_WIDTH),
  localparam int unsigned YW = $clog2(IMG_HEIGHT),
  localparam int unsigned SW = $clog2(MAX_STRIDE + 1)
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [SW-1:0]         cfg_stride_x,
  input  logic [SW-1:0]         cfg_stride_y,
  input  logic                  data_in_valid,
  input  logic [DATA_WIDTH-1:0] data_in_data,
  output logic                  data_in_ready,
  output logic                  data_out_valid,
  output logic [DATA_WIDTH-1:0] data_out_data,
  output logic                  data_out_last,
  input  logic                  data_out_ready,
  output logic                  frame_done
);

  localparam logic [XW-1:0] XMax = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YMax = YW'(IMG_HEIGHT - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [SW-1:0] px_q, px_d;
  logic [SW-1:0] py_q, py_d;
  logic [SW-1:0] sx_q, sx_d;
  logic [SW-1:0] sy_q, sy_d;
  logic          frame_done_q;

  logic [SW-1:0] cfg_sx;
  logic [SW-1:0] cfg_sy;
  logic [SW-1:0] sx_eff;
  logic [SW-1:0] sy_eff;
  logic          at_origin;
  logic          x_end;
  logic          y_end;
  logic          keep;
  logic          last;
  logic          xfer;
  logic          skid_ready;
  logic [DATA_WIDTH:0] skid_out;

  assign cfg_sx = SW'(clamp_stride(32'(cfg_stride_x), MAX_STRIDE));
  assign cfg_sy = SW'(clamp_stride(32'(cfg_stride_y), MAX_STRIDE));

  // Before the first transfer of a frame the live cfg governs, so pixel (0,0) already
  // advances the phase counters with the stride that will be frozen for the frame.
  assign at_origin = (x_q == '0) && (y_q == '0);
  assign sx_eff    = at_origin ? cfg_sx : sx_q;
  assign sy_eff    = at_origin ? cfg_sy : sy_q;

  assign x_end = (x_q == XMax);
  assign y_end = (y_q == YMax);
  assign keep  = (px_q == '0) && (py_q == '0);
  assign last  = (32'(x_q) + 32'(sx_eff) > IMG_WIDTH - 1) &&
                 (32'(y_q) + 32'(sy_eff) > IMG_HEIGHT - 1);

  // Dropped pixels are always consumed; kept ones wait on the buffer's registered flag.
  assign data_in_ready = keep ? skid_ready : 1'b1;
  assign xfer          = data_in_valid & data_in_ready;

  // Position, phase and stride next-state.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    px_d = px_q;
    py_d = py_q;
    sx_d = at_origin ? cfg_sx : sx_q;
    sy_d = at_origin ? cfg_sy : sy_q;
    if (xfer) begin
      if (x_end) begin
        x_d  = '0;
        px_d = '0;
        if (y_end) begin
          y_d  = '0;
          py_d = '0;
        end else begin
          y_d  = y_q + YW'(1);
          py_d = (py_q + SW'(1) == sy_eff) ? '0 : py_q + SW'(1);
        end
      end else begin
        x_d  = x_q + XW'(1);
        px_d = (px_q + SW'(1) == sx_eff) ? '0 : px_q + SW'(1);
      end
    end
  end

  // Counter, stride and frame-end registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      x_q          <= '0;
      y_q          <= '0;
      px_q         <= '0;
      py_q         <= '0;
      sx_q         <= SW'(1);
      sy_q         <= SW'(1);
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      px_q         <= px_d;
      py_q         <= py_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      frame_done_q <= xfer & x_end & y_end;
    end
  end

  downsample_skid #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .in_valid (data_in_valid & keep),
    .in_data  ({last, data_in_data}),
    .in_ready (skid_ready),
    .out_valid(data_out_valid),
    .out_data (skid_out),
    .out_ready(data_out_ready)
  );

  assign data_out_data = skid_out[DATA_WIDTH-1:0];
  assign data_out_last = skid_out[DATA_WIDTH];
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_downsample_2d.sv
// Scoreboard bench for downsample_2d on an 8x4 image: a frame-level model predicts kept
// pixels and last flags; a negedge monitor pops and compares every output transfer.
module tb_downsample_2d;

  localparam int DW = 16;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int MS = 4;
  localparam int SW = $clog2(MS + 1);

  logic          CLK = 1'b0;
  logic          RESETN;
  logic [SW-1:0] cfg_stride_x;
  logic [SW-1:0] cfg_stride_y;
  logic          data_in_valid;
  logic [DW-1:0] data_in_data;
  logic          data_in_ready;
  logic          data_out_valid;
  logic [DW-1:0] data_out_data;
  logic          data_out_last;
  logic          data_out_ready;
  logic          frame_done;

  downsample_2d #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .MAX_STRIDE(MS)
  ) dut (
    .CLK           (CLK),
    .RESETN        (RESETN),
    .cfg_stride_x  (cfg_stride_x),
    .cfg_stride_y  (cfg_stride_y),
    .data_in_valid (data_in_valid),
    .data_in_data  (data_in_data),
    .data_in_ready (data_in_ready),
    .data_out_valid(data_out_valid),
    .data_out_data (data_out_data),
    .data_out_last (data_out_last),
    .data_out_ready(data_out_ready),
    .frame_done    (frame_done)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state: position in frame and the frame's captured strides.
  int n      = 0;
  int msx    = 1;
  int msy    = 1;
  int fd_due = -1;

  logic [DW:0] exp_q[$];
  logic [DW:0] got_q[$];
  int out_cnt       = 0;
  int first_out_cyc = 0;
  int last_out_cyc  = 0;
  int fd_seen       = 0;
  int stall_cycles  = 0;
  int ready_mode    = 0;
  int t0            = 0;
  bit mon_en        = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int clampc(input int c);
    if (c == 0) return 1;
    if (c > MS) return MS;
    return c;
  endfunction

  // Frame-level reference: keep on stride multiples, last on the final kept pixel.
  task automatic model_accept(input logic [DW-1:0] d);
    int x;
    int y;
    bit k;
    bit l;
    if (n == 0) begin
      msx = clampc(int'(cfg_stride_x));
      msy = clampc(int'(cfg_stride_y));
    end
    x = n % W;
    y = n / W;
    k = (x % msx == 0) && (y % msy == 0);
    l = (x + msx > W - 1) && (y + msy > H - 1);
    if (k) exp_q.push_back({l, d});
    if (n == W * H - 1) begin
      fd_due = cyc + 1;
      n = 0;
    end else begin
      n++;
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  initial begin
    data_out_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (ready_mode)
        1:       data_out_ready = ($urandom_range(0, 3) != 0);
        2:       data_out_ready = !((cyc - t0) >= 2 && (cyc - t0) <= 8);
        default: data_out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every output transfer, output hold, and frame_done timing.
  initial begin
    logic [DW:0] hold_v;
    logic [DW:0] e;
    bit hold_act;
    hold_act = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESETN || !mon_en) begin
        hold_act = 1'b0;
      end else begin
        if (hold_act && data_out_valid)
          check("out_hold_stable", int'({data_out_last, data_out_data}), int'(hold_v));
        hold_act = 1'b0;
        if (data_out_valid && data_out_ready) begin
          got_q.push_back({data_out_last, data_out_data});
          if (exp_q.size() == 0) begin
            check("out_unexpected", int'(data_out_data), -1);
          end else begin
            e = exp_q.pop_front();
            check("out_data", int'(data_out_data), int'(e[DW-1:0]));
            check("out_last", int'(data_out_last), int'(e[DW]));
          end
          out_cnt++;
          if (out_cnt == 1) first_out_cyc = cyc;
          last_out_cyc = cyc;
        end else if (data_out_valid) begin
          hold_act = 1'b1;
          hold_v   = {data_out_last, data_out_data};
        end
        if (frame_done) fd_seen++;
        if (frame_done || cyc == fd_due) check("frame_done", int'(frame_done), int'(cyc == fd_due));
      end
    end
  end

  task automatic sync();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int waited;
    bit drop;
    int x;
    int y;
    waited = 0;
    x = n % W;
    y = n / W;
    drop = (n != 0) && !((x % msx == 0) && (y % msy == 0));
    data_in_valid = 1'b1;
    data_in_data  = d;
    forever begin
      @(negedge CLK);
      if (drop && waited == 0) check("drop_ready", int'(data_in_ready), 1);
      if (data_in_ready) break;
      stall_cycles++;
      waited++;
      if (waited > 200) break;
    end
    if (waited > 200) begin
      check("in_ready_timeout", 0, 1);
      sync();
      data_in_valid = 1'b0;
      return;
    end
    model_accept(d);
    sync();
    data_in_valid = 1'b0;
  endtask

  // Pattern 0: data = y*W+x; pattern 1: random data, random gaps, cfg scrambled per pixel.
  task automatic send_pixels(input int from, input int to, input int pattern);
    for (int i = from; i < to; i++) begin
      if (pattern == 0) begin
        send(DW'(i));
      end else begin
        send(DW'($urandom));
        cfg_stride_x = SW'($urandom_range(0, 7));
        cfg_stride_y = SW'($urandom_range(0, 7));
        repeat ($urandom_range(0, 2)) sync();
      end
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 500) begin
      @(negedge CLK);
      b++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (4) @(negedge CLK);
    sync();
  endtask

  task automatic start_test(input int sx, input int sy, input int mode);
    cfg_stride_x = SW'(sx);
    cfg_stride_y = SW'(sy);
    ready_mode   = mode;
    got_q.delete();
    out_cnt      = 0;
    fd_seen      = 0;
    stall_cycles = 0;
    t0           = cyc;
  endtask

  initial begin
    int exp21[8];
    int stalls_before;
    exp21 = '{0, 2, 4, 6, 16, 18, 20, 22};
    RESETN        = 1'b0;
    cfg_stride_x  = SW'(1);
    cfg_stride_y  = SW'(1);
    data_in_valid = 1'b0;
    data_in_data  = '0;
    repeat (3) @(negedge CLK);
    check("rst_out_valid", int'(data_out_valid), 0);
    check("rst_out_last", int'(data_out_last), 0);
    check("rst_out_data", int'(data_out_data), 0);
    check("rst_frame_done", int'(frame_done), 0);
    sync();
    RESETN = 1'b1;
    mon_en = 1'b1;
    sync();
    check("idle_in_ready", int'(data_in_ready), 1);

    // Stride 2,2: known output list, last only on 22, one frame_done.
    start_test(2, 2, 0);
    send_pixels(0, W * H, 0);
    drain();
    check("s22_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      check("s22_data", int'(got_q[i][DW-1:0]), exp21[i]);
      check("s22_last", int'(got_q[i][DW]), int'(i == 7));
    end
    check("s22_frame_done_cnt", fd_seen, 1);

    // Stride 3,1: columns 0,3,6 of every row, last on 30.
    start_test(3, 1, 0);
    send_pixels(0, W * H, 0);
    drain();
    check("s31_count", got_q.size(), 12);
    if (got_q.size() == 12) check("s31_final", int'(got_q[11]), int'({1'b1, 16'd30}));

    // Stride 1,1 continuous: no input stall, 32 outputs on consecutive cycles.
    start_test(1, 1, 0);
    send_pixels(0, W * H, 0);
    drain();
    check("s11_no_stall", stall_cycles, 0);
    check("s11_count", out_cnt, 32);
    check("s11_span", last_out_cyc - first_out_cyc, 31);

    // Stride 2,2 with output back-pressure early in the frame.
    start_test(2, 2, 2);
    send_pixels(0, W * H, 0);
    drain();
    check("bp_kept_stalled", int'(stall_cycles > 0), 1);
    check("bp_count", out_cnt, 8);
    ready_mode = 0;

    // cfg change mid-frame applies from the next frame only.
    start_test(2, 2, 0);
    send_pixels(0, 10, 0);
    cfg_stride_x = SW'(1);
    cfg_stride_y = SW'(1);
    send_pixels(10, W * H, 0);
    send_pixels(0, W * H, 0);
    drain();
    check("cfgchg_count", out_cnt, 8 + 32);
    check("cfgchg_frame_done_cnt", fd_seen, 2);

    // Reset mid-frame: outputs clear at once, next pixel is (0,0), cfg 0,5 acts as 1,4.
    start_test(2, 2, 0);
    ready_mode = 0;
    data_out_ready = 1'b0;
    ready_mode = 3;
    send_pixels(0, 14, 0);
    RESETN = 1'b0;
    #1;
    check("rst_mid_out_valid", int'(data_out_valid), 0);
    check("rst_mid_out_data", int'(data_out_data), 0);
    exp_q.delete();
    n      = 0;
    fd_due = -1;
    sync();
    RESETN       = 1'b1;
    ready_mode   = 0;
    cfg_stride_x = SW'(0);
    cfg_stride_y = SW'(5);
    got_q.delete();
    out_cnt = 0;
    sync();
    send_pixels(0, W * H, 0);
    drain();
    check("rst_cfg_count", out_cnt, 8);
    if (got_q.size() == 8) begin
      check("rst_first", int'(got_q[0]), 0);
      check("rst_final", int'(got_q[7]), int'({1'b1, 16'd7}));
    end

    // Randomized frames with random back-pressure, gaps and scrambled cfg.
    for (int f = 0; f < 6; f++) begin
      start_test(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1);
      stalls_before = 0;
      send_pixels(0, W * H, 1);
      drain();
      check("rand_frame_done_cnt", fd_seen, 1);
    end
    ready_mode = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
